// File: rtl/nyq_frame_assembler.sv
// NYQ frame assembler: writes serial samples into down-counting frame slots and hands each
// completed frame downstream as one parallel word over valid/ready, double-buffered.
module nyq_frame_assembler #(
  parameter int SAMPLE_W  = 8,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 3
) (
  input  logic                          Clk_CI,
  input  logic                          Rst_RBI,
  input  logic [SAMPLE_W-1:0]           Samp_DI,
  input  logic                          Samp_Valid_SI,
  input  logic                          Frame_Start_SI,
  output logic [SAMPLE_W*FRAME_LEN-1:0] Frame_DO,
  output logic                          Frame_Valid_SO,
  input  logic                          Frame_Ready_SI,
  output logic [CNT_W-1:0]              Slot_DO,
  output logic [7:0]                    Frame_Cnt_DO,
  output logic                          Overflow_SO,
  input  logic                          Clr_Overflow_SI,
  output logic                          Sync_Err_SO
);

  localparam int                FRAME_W   = SAMPLE_W * FRAME_LEN;
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  PRE_SLOT  = CNT_W'(FRAME_LEN - 2);
  localparam int                TOP_LSB   = (FRAME_LEN - 1) * SAMPLE_W;

  typedef enum logic {
    UNSYNC,
    ASSEMBLE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     slot_q, slot_d;
  logic [FRAME_W-1:0]   asm_q, asm_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 sync_err_q, sync_err_d;

  logic [FRAME_W-1:0]   done_word;
  logic                 complete;
  logic                 transfer;
  logic                 can_load;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    asm_d         = asm_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    frame_cnt_d   = frame_cnt_q;
    overflow_d    = overflow_q;
    sync_err_d    = 1'b0;
    done_word     = asm_q;
    complete      = 1'b0;
    transfer      = frame_valid_q & Frame_Ready_SI;
    can_load      = ~frame_valid_q | transfer;

    if (Samp_Valid_SI) begin
      if (Frame_Start_SI) begin
        // A start always realigns to the top slot and throws away any partial frame.
        asm_d                         = '0;
        asm_d[TOP_LSB +: SAMPLE_W]    = Samp_DI;
        slot_d                        = PRE_SLOT;
        state_d                       = ASSEMBLE;
        sync_err_d                    = (state_q == ASSEMBLE) && (slot_q != LAST_SLOT);
      end else if (state_q == ASSEMBLE) begin
        // done_word carries the current sample so the slot-0 write reaches Frame_DO directly.
        done_word[int'(slot_q) * SAMPLE_W +: SAMPLE_W] = Samp_DI;
        asm_d = done_word;
        if (slot_q == '0) begin
          complete = 1'b1;
          slot_d   = LAST_SLOT;
        end else begin
          slot_d = slot_q - 1'b1;
        end
      end
    end

    if (transfer) begin
      frame_valid_d = 1'b0;
      frame_cnt_d   = frame_cnt_q + 8'd1;
    end

    if (complete && can_load) begin
      frame_d       = done_word;
      frame_valid_d = 1'b1;
    end

    if (complete && !can_load) begin
      overflow_d = 1'b1;
    end else if (Clr_Overflow_SI) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q       <= UNSYNC;
      slot_q        <= LAST_SLOT;
      asm_q         <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
      overflow_q    <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      asm_q         <= asm_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_cnt_q   <= frame_cnt_d;
      overflow_q    <= overflow_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign Frame_DO       = frame_q;
  assign Frame_Valid_SO = frame_valid_q;
  assign Slot_DO        = slot_q;
  assign Frame_Cnt_DO   = frame_cnt_q;
  assign Overflow_SO    = overflow_q;
  assign Sync_Err_SO    = sync_err_q;

endmodule

// File: tb/tb_nyq_frame_assembler.sv
// Scoreboard bench for nyq_frame_assembler: directed sample streams push expected frames,
// a negedge monitor pops and compares each frame actually handed off.
module tb_nyq_frame_assembler;

  logic        clk;
  logic        rst_n;
  logic [7:0]  samp;
  logic        samp_valid;
  logic        frame_start;
  logic [63:0] frame_do;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  slot;
  logic [7:0]  frame_cnt;
  logic        overflow;
  logic        clr_overflow;
  logic        sync_err;

  int          n_compared;
  int          n_mismatched;
  logic [63:0] exp_q[$];

  nyq_frame_assembler #(.SAMPLE_W(8), .FRAME_LEN(8), .CNT_W(3)) dut (
    .Clk_CI          (clk),
    .Rst_RBI         (rst_n),
    .Samp_DI         (samp),
    .Samp_Valid_SI   (samp_valid),
    .Frame_Start_SI  (frame_start),
    .Frame_DO        (frame_do),
    .Frame_Valid_SO  (frame_valid),
    .Frame_Ready_SI  (frame_ready),
    .Slot_DO         (slot),
    .Frame_Cnt_DO    (frame_cnt),
    .Overflow_SO     (overflow),
    .Clr_Overflow_SI (clr_overflow),
    .Sync_Err_SO     (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mkFrame(input logic [7:0] base);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[(7 - k) * 8 +: 8] = base + 8'(k);
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic st, input logic [7:0] d);
    samp_valid  = v;
    frame_start = st;
    samp        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sendSamples(input logic [7:0] base, input int n, input logic with_start);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, with_start && (i == 0), base + 8'(i));
  endtask

  // Monitor: every handoff the DUT makes must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_handoff", frame_do, 64'h0);
        if (frame_do == 64'h0) begin
          n_mismatched++;
          $display("[TB] FAIL unexpected_handoff: got a frame, expected none");
        end
      end else begin
        checkOutput("handoff_frame", frame_do, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    samp         = '0;
    samp_valid   = 1'b0;
    frame_start  = 1'b0;
    frame_ready  = 1'b0;
    clr_overflow = 1'b0;

    #12;
    checkOutput("rst_slot", 64'(slot), 64'd7);
    checkOutput("rst_valid", 64'(frame_valid), 64'd0);
    checkOutput("rst_frame", frame_do, 64'h0);
    checkOutput("rst_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    checkOutput("rst_syncerr", 64'(sync_err), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unsynchronised samples and starts without valid are ignored.
    sendSamples(8'hAA, 3, 1'b0);
    checkOutput("unsync_slot", 64'(slot), 64'd7);
    checkOutput("unsync_valid", 64'(frame_valid), 64'd0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("start_novalid_slot", 64'(slot), 64'd7);

    // First frame with downstream ready.
    frame_ready = 1'b1;
    exp_q.push_back(mkFrame(8'h10));
    sendSamples(8'h10, 8, 1'b1);
    checkOutput("f1_valid", 64'(frame_valid), 64'd1);
    checkOutput("f1_frame", frame_do, 64'h1011121314151617);
    checkOutput("f1_slot", 64'(slot), 64'd7);
    checkOutput("f1_syncerr", 64'(sync_err), 64'd0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("f1_cnt", 64'(frame_cnt), 64'd1);
    checkOutput("f1_valid_drop", 64'(frame_valid), 64'd0);

    // Backpressure: held frame stays stable, second completion is dropped.
    frame_ready = 1'b0;
    sendSamples(8'h20, 8, 1'b1);
    checkOutput("bp_valid", 64'(frame_valid), 64'd1);
    checkOutput("bp_frame", frame_do, mkFrame(8'h20));
    sendSamples(8'h30, 8, 1'b0);
    checkOutput("ovf_set", 64'(overflow), 64'd1);
    checkOutput("ovf_frame_held", frame_do, mkFrame(8'h20));
    checkOutput("ovf_valid_held", 64'(frame_valid), 64'd1);
    clr_overflow = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    clr_overflow = 1'b0;
    checkOutput("ovf_clr", 64'(overflow), 64'd0);
    sendSamples(8'h40, 7, 1'b0);
    clr_overflow = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h47);
    clr_overflow = 1'b0;
    checkOutput("ovf_set_over_clr", 64'(overflow), 64'd1);
    checkOutput("ovf2_frame_held", frame_do, mkFrame(8'h20));
    clr_overflow = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    clr_overflow = 1'b0;
    checkOutput("ovf_clr2", 64'(overflow), 64'd0);

    // Ready pulsed in the completion cycle: old frame leaves, new one loads.
    exp_q.push_back(mkFrame(8'h20));
    exp_q.push_back(mkFrame(8'h50));
    sendSamples(8'h50, 7, 1'b0);
    frame_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h57);
    frame_ready = 1'b0;
    checkOutput("swap_valid", 64'(frame_valid), 64'd1);
    checkOutput("swap_frame", frame_do, mkFrame(8'h50));
    checkOutput("swap_ovf", 64'(overflow), 64'd0);
    checkOutput("swap_cnt", 64'(frame_cnt), 64'd2);
    frame_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("swap_cnt2", 64'(frame_cnt), 64'd3);
    checkOutput("swap_valid_drop", 64'(frame_valid), 64'd0);

    // Resync after three samples, with gaps in between.
    exp_q.push_back(mkFrame(8'h70));
    sendSamples(8'h60, 3, 1'b1);
    checkOutput("part_slot", 64'(slot), 64'd4);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("gap_slot", 64'(slot), 64'd4);
    applyStimulus(1'b1, 1'b1, 8'h70);
    checkOutput("resync_err", 64'(sync_err), 64'd1);
    checkOutput("resync_slot", 64'(slot), 64'd6);
    applyStimulus(1'b1, 1'b0, 8'h71);
    checkOutput("resync_err_pulse", 64'(sync_err), 64'd0);
    sendSamples(8'h72, 6, 1'b0);
    checkOutput("resync_valid", 64'(frame_valid), 64'd1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("resync_cnt", 64'(frame_cnt), 64'd4);

    // Start on slot 7 while assembling is not a sync error.
    exp_q.push_back(mkFrame(8'h80));
    applyStimulus(1'b1, 1'b1, 8'h80);
    checkOutput("aligned_noerr", 64'(sync_err), 64'd0);
    checkOutput("aligned_slot", 64'(slot), 64'd6);
    sendSamples(8'h81, 7, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("aligned_cnt", 64'(frame_cnt), 64'd5);

    // Asynchronous reset in the middle of a cycle and a frame.
    frame_ready = 1'b0;
    sendSamples(8'h90, 8, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hA0);
    applyStimulus(1'b1, 1'b0, 8'hA1);
    samp_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_slot", 64'(slot), 64'd7);
    checkOutput("arst_valid", 64'(frame_valid), 64'd0);
    checkOutput("arst_frame", frame_do, 64'h0);
    checkOutput("arst_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("arst_ovf", 64'(overflow), 64'd0);
    checkOutput("arst_syncerr", 64'(sync_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b1;
    sendSamples(8'hB0, 8, 1'b0);
    checkOutput("postrst_valid", 64'(frame_valid), 64'd0);
    checkOutput("postrst_slot", 64'(slot), 64'd7);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
